// File: rtl/dcache_arb_pkg.sv
// Shared definitions for the data-cache port arbiter: requester indices and
// the request payload record.
package dcache_arb_pkg;

    localparam int ARB_ADDR_W = 30;
    localparam int ARB_DATA_W = 32;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

    typedef struct packed {
        logic [3:0]            we;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
    } arb_req_t;

endpackage

// File: rtl/dcache_port_arbiter.sv
// Arbitrates the single data-cache RAM port between the CPU memory stage and
// the DMA/debug engine, and steers each 1-cycle-late read result to its owner.
module dcache_port_arbiter
    import dcache_arb_pkg::*;
#(
    parameter int ADDR_W       = 30,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                cpu_req_valid,
    output logic                cpu_req_ready,
    input  logic [DATA_W/8-1:0] cpu_req_we,
    input  logic [ADDR_W-1:0]   cpu_req_addr,
    input  logic [DATA_W-1:0]   cpu_req_wdata,
    output logic                cpu_resp_valid,
    output logic [DATA_W-1:0]   cpu_resp_rdata,

    input  logic                dma_req_valid,
    output logic                dma_req_ready,
    input  logic [DATA_W/8-1:0] dma_req_we,
    input  logic [ADDR_W-1:0]   dma_req_addr,
    input  logic [DATA_W-1:0]   dma_req_wdata,
    output logic                dma_resp_valid,
    output logic [DATA_W-1:0]   dma_resp_rdata,

    output logic [DATA_W/8-1:0] mem_write_en,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_in_data,
    input  logic [DATA_W-1:0]   mem_out_data
);

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] starve_next;
    logic             starve_hit;
    logic             grant_cpu;
    logic             grant_dma;
    logic             resp_pending;
    logic             resp_owner;

    // Handshake: a request transfers when valid && ready. Requesters hold valid
    // and payload until ready; ready is a pure function of both valids and the
    // starvation count, never of ready itself.
    always_comb begin
        starve_hit = (starve_cnt == LIMIT);
        grant_dma  = dma_req_valid && (!cpu_req_valid || starve_hit);
        grant_cpu  = cpu_req_valid && !grant_dma;
    end

    assign cpu_req_ready = grant_cpu;
    assign dma_req_ready = grant_dma;

    always_comb begin
        starve_next = starve_cnt;
        if (!dma_req_valid || grant_dma) begin
            starve_next = '0;
        end else if (grant_cpu && !starve_hit) begin
            starve_next = starve_cnt + 1'b1;
        end
    end

    // With no grant the address/data lines idle on the CPU payload.
    always_comb begin
        mem_write_en = '0;
        mem_addr     = cpu_req_addr;
        mem_in_data  = cpu_req_wdata;
        if (grant_dma) begin
            mem_write_en = dma_req_we;
            mem_addr     = dma_req_addr;
            mem_in_data  = dma_req_wdata;
        end else if (grant_cpu) begin
            mem_write_en = cpu_req_we;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt   <= '0;
            resp_pending <= 1'b0;
            resp_owner   <= REQ_CPU;
        end else begin
            starve_cnt   <= starve_next;
            resp_pending <= grant_cpu || grant_dma;
            if (grant_cpu || grant_dma) begin
                resp_owner <= grant_dma ? REQ_DMA : REQ_CPU;
            end
        end
    end

    assign cpu_resp_valid = resp_pending && (resp_owner == REQ_CPU);
    assign dma_resp_valid = resp_pending && (resp_owner == REQ_DMA);
    assign cpu_resp_rdata = mem_out_data;
    assign dma_resp_rdata = mem_out_data;

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Bench for dcache_port_arbiter: directed vector table, contention and reset
// sequences, then random traffic checked against a word-level reference model.
module tb_dcache_port_arbiter;
    import dcache_arb_pkg::*;

    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;
    localparam int LIMIT  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              cpu_req_valid, cpu_req_ready;
    logic [3:0]        cpu_req_we;
    logic [ADDR_W-1:0] cpu_req_addr;
    logic [DATA_W-1:0] cpu_req_wdata;
    logic              cpu_resp_valid;
    logic [DATA_W-1:0] cpu_resp_rdata;
    logic              dma_req_valid, dma_req_ready;
    logic [3:0]        dma_req_we;
    logic [ADDR_W-1:0] dma_req_addr;
    logic [DATA_W-1:0] dma_req_wdata;
    logic              dma_resp_valid;
    logic [DATA_W-1:0] dma_resp_rdata;
    logic [3:0]        mem_write_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_in_data;
    logic [DATA_W-1:0] mem_out_data;

    dcache_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
        .cpu_req_we(cpu_req_we), .cpu_req_addr(cpu_req_addr),
        .cpu_req_wdata(cpu_req_wdata), .cpu_resp_valid(cpu_resp_valid),
        .cpu_resp_rdata(cpu_resp_rdata),
        .dma_req_valid(dma_req_valid), .dma_req_ready(dma_req_ready),
        .dma_req_we(dma_req_we), .dma_req_addr(dma_req_addr),
        .dma_req_wdata(dma_req_wdata), .dma_resp_valid(dma_resp_valid),
        .dma_resp_rdata(dma_resp_rdata),
        .mem_write_en(mem_write_en), .mem_addr(mem_addr),
        .mem_in_data(mem_in_data), .mem_out_data(mem_out_data)
    );

    // clock / reset
    always #5 clk = ~clk;

    // RAM attached to the arbiter: registered read, byte-enabled write.
    logic [DATA_W-1:0] ram [256];
    logic              ram_fill;
    always @(posedge clk) begin
        if (ram_fill) begin
            for (int i = 0; i < 256; i++) ram[i] <= 32'hA500_0000 | 32'(i);
        end else begin
            mem_out_data <= ram[mem_addr[7:0]];
            for (int b = 0; b < 4; b++)
                if (mem_write_en[b]) ram[mem_addr[7:0]][8*b +: 8] <= mem_in_data[8*b +: 8];
        end
    end

    // reference model state
    logic [DATA_W-1:0] ref_ram [256];
    int                ref_starve;
    int                n_checks = 0;
    int                n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic arb_req_t mk(input logic [3:0] we, input logic [29:0] addr, input logic [31:0] wd);
        arb_req_t r;
        r.we = we; r.addr = addr; r.wdata = wd;
        return r;
    endfunction

    // driver
    task automatic drive(input logic cv, input arb_req_t cr, input logic dv, input arb_req_t dr);
        cpu_req_valid = cv; cpu_req_we = cr.we; cpu_req_addr = cr.addr; cpu_req_wdata = cr.wdata;
        dma_req_valid = dv; dma_req_we = dr.we; dma_req_addr = dr.addr; dma_req_wdata = dr.wdata;
    endtask

    // One clock of checking: grant/mem outputs mid-cycle, then the response
    // for that grant just after the edge. Called at posedge+1 with inputs set.
    task automatic cycle(output logic gc, output logic gd);
        logic ec, ed;
        logic [3:0]  ewe;
        logic [29:0] a;
        logic [31:0] wd, erd;
        @(negedge clk);
        ed = dma_req_valid && (!cpu_req_valid || ref_starve == LIMIT);
        ec = cpu_req_valid && !ed;
        check("starve_cnt", 64'(dut.starve_cnt), 64'(ref_starve));
        check("cpu_req_ready", cpu_req_ready, ec);
        check("dma_req_ready", dma_req_ready, ed);
        ewe = ec ? cpu_req_we : (ed ? dma_req_we : 4'h0);
        a   = ed ? dma_req_addr : cpu_req_addr;
        wd  = ed ? dma_req_wdata : cpu_req_wdata;
        check("mem_write_en", mem_write_en, ewe);
        if (ec || ed) check("mem_addr", mem_addr, a);
        if (ewe != 4'h0) check("mem_in_data", mem_in_data, wd);
        erd = ref_ram[a[7:0]];
        if (ec || ed)
            for (int b = 0; b < 4; b++)
                if (ewe[b]) ref_ram[a[7:0]][8*b +: 8] = wd[8*b +: 8];
        if (dma_req_valid && ec) ref_starve = (ref_starve + 1 > LIMIT) ? LIMIT : ref_starve + 1;
        else ref_starve = 0;
        @(posedge clk); #1;
        check("cpu_resp_valid", cpu_resp_valid, ec);
        check("dma_resp_valid", dma_resp_valid, ed);
        if (ec) check("cpu_resp_rdata", cpu_resp_rdata, erd);
        if (ed) check("dma_resp_rdata", dma_resp_rdata, erd);
        gc = ec; gd = ed;
    endtask

    typedef struct packed {
        logic     cv;
        arb_req_t cr;
        logic     dv;
        arb_req_t dr;
        logic     ec;
        logic     ed;
        logic     chk;
        logic [31:0] erd;
    } vec_t;

    vec_t     vecs [11];
    arb_req_t nil;
    arb_req_t c_r, d_r;
    logic     c_v, d_v, gc, gd;
    int       cpu_grants, dma_grants;

    task automatic new_req(output logic v, output arb_req_t r);
        v = ($urandom_range(0, 99) < 70);
        r = mk(($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15)),
               30'($urandom_range(0, 15)), $urandom);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        nil = mk(4'h0, 30'h0, 32'h0);
        vecs[0]  = '{1'b1, mk(4'hF, 30'h10, 32'hDEADBEEF), 1'b0, nil, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, mk(4'h0, 30'h10, 32'h0),        1'b0, nil, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF};
        vecs[2]  = '{1'b0, nil, 1'b1, mk(4'hF, 30'h30, 32'h11223344), 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, nil, 1'b1, mk(4'b0010, 30'h30, 32'h0000AB00), 1'b0, 1'b1, 1'b1, 32'h11223344};
        vecs[4]  = '{1'b0, nil, 1'b1, mk(4'h0, 30'h30, 32'h0), 1'b0, 1'b1, 1'b1, 32'h1122AB44};
        vecs[5]  = '{1'b0, nil, 1'b1, mk(4'hF, 30'h20, 32'h5), 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, mk(4'h0, 30'h20, 32'h0), 1'b0, nil, 1'b1, 1'b0, 1'b1, 32'h5};
        vecs[7]  = '{1'b0, nil, 1'b0, nil, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[8]  = '{1'b1, mk(4'hF, 30'h40, 32'hCAFEF00D), 1'b1, mk(4'h0, 30'h40, 32'h0), 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, nil, 1'b1, mk(4'h0, 30'h40, 32'h0), 1'b0, 1'b1, 1'b1, 32'hCAFEF00D};
        vecs[10] = '{1'b0, nil, 1'b0, nil, 1'b0, 1'b0, 1'b0, 32'h0};

        for (int i = 0; i < 256; i++) ref_ram[i] = 32'hA500_0000 | 32'(i);
        ref_starve = 0;
        rst = 1'b1;
        ram_fill = 1'b1;
        drive(1'b0, nil, 1'b0, nil);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("reset cpu_resp_valid", cpu_resp_valid, 1'b0);
        check("reset dma_resp_valid", dma_resp_valid, 1'b0);
        check("reset starve_cnt", 64'(dut.starve_cnt), 64'd0);
        rst = 1'b0;
        ram_fill = 1'b0;

        // directed vector table; first row lands on the first cycle after release
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].cv, vecs[i].cr, vecs[i].dv, vecs[i].dr);
            cycle(gc, gd);
            check($sformatf("vec%0d cpu grant", i), gc, vecs[i].ec);
            check($sformatf("vec%0d dma grant", i), gd, vecs[i].ed);
            if (vecs[i].chk)
                check($sformatf("vec%0d rdata", i), vecs[i].ec ? cpu_resp_rdata : dma_resp_rdata, vecs[i].erd);
        end

        // full contention: CCCCD repeating
        cpu_grants = 0; dma_grants = 0;
        c_r = mk(4'h0, 30'h50, 32'h0);
        d_r = mk(4'h0, 30'h60, 32'h0);
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, c_r, 1'b1, d_r);
            cycle(gc, gd);
            check($sformatf("contention dma grant k=%0d", k), gd, (k % 5) == 4);
            if (gc) begin cpu_grants++; c_r.addr = c_r.addr + 30'd1; end
            if (gd) begin dma_grants++; d_r.addr = d_r.addr + 30'd1; end
        end
        check("contention cpu grants", 64'(cpu_grants), 64'd16);
        check("contention dma grants", 64'(dma_grants), 64'd4);

        // DMA gives up mid-wait: counter must clear
        drive(1'b1, mk(4'h0, 30'h1, 32'h0), 1'b1, mk(4'h0, 30'h2, 32'h0));
        cycle(gc, gd);
        cycle(gc, gd);
        drive(1'b1, mk(4'h0, 30'h3, 32'h0), 1'b0, nil);
        cycle(gc, gd);
        check("starve cleared after dma drop", 64'(dut.starve_cnt), 64'd0);

        // reset while a read response is outstanding
        drive(1'b1, mk(4'h0, 30'h10, 32'h0), 1'b1, mk(4'hF, 30'h11, 32'h77));
        cycle(gc, gd);
        cycle(gc, gd);
        rst = 1'b1;
        #2;
        check("midreset cpu_resp_valid", cpu_resp_valid, 1'b0);
        check("midreset dma_resp_valid", dma_resp_valid, 1'b0);
        ref_starve = 0;
        drive(1'b0, nil, 1'b0, nil);
        @(posedge clk); #1;
        rst = 1'b0;
        check("starve after reset release", 64'(dut.starve_cnt), 64'd0);

        // idle: no grants, no responses, counter holds at zero
        for (int k = 0; k < 3; k++) cycle(gc, gd);

        // random traffic with held payloads until accepted
        new_req(c_v, c_r);
        new_req(d_v, d_r);
        for (int k = 0; k < 400; k++) begin
            drive(c_v, c_r, d_v, d_r);
            cycle(gc, gd);
            if (gc || !c_v) new_req(c_v, c_r);
            if (gd || !d_v) new_req(d_v, d_r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_port_arbiter.md
# dcache_port_arbiter

Shares the single synchronous port of the data cache RAM between two requesters: the CPU memory stage (requester 0) and the DMA/debug engine (requester 1). Grants at most one access per cycle. CPU has fixed priority, bounded by a starvation counter that forces a DMA grant. The block routes each RAM read result, which returns one cycle after issue, back to the requester that issued it.

## Interface
- `ADDR_W`, 30: word-address width (byte address bits [31:2]).
- `DATA_W`, 32: data width; byte enables are `DATA_W/8` wide.
- `STARVE_LIMIT`, 4: consecutive CPU wins while DMA waits before DMA is forced; legal range 1..255.

- `clk` in 1: single clock, all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cpu_req_valid` in 1: CPU request present.
- `cpu_req_ready` out 1: CPU request accepted this cycle.
- `cpu_req_we` in 4: byte write enables; 0 means read.
- `cpu_req_addr` in `ADDR_W`: word address.
- `cpu_req_wdata` in `DATA_W`: write data.
- `cpu_resp_valid` out 1: response for the CPU access accepted the previous cycle.
- `cpu_resp_rdata` out `DATA_W`: RAM word (pre-write contents for writes).
- `dma_req_valid`, `dma_req_ready`, `dma_req_we`, `dma_req_addr`, `dma_req_wdata`, `dma_resp_valid`, `dma_resp_rdata`: same meaning for the DMA requester.
- `mem_write_en` out 4: RAM byte write enables.
- `mem_addr` out `ADDR_W`: RAM word address.
- `mem_in_data` out `DATA_W`: RAM write data.
- `mem_out_data` in `DATA_W`: RAM registered read data (1-cycle latency).

## Operation
- **Handshake:** a request transfers when `valid && ready`. The requester holds `valid` and its payload stable until `ready` is high. `ready` is combinational from both `valid` inputs and the starvation state. It never depends on `ready` itself.
- **Grant rule, when only one requester is valid:** that requester is granted.
- **Grant rule, when both are valid:** CPU is granted unless `starve_cnt == STARVE_LIMIT`, in which case DMA is granted.
- **Grant rule, when neither is valid:** no grant.
- **`starve_cnt` update (registered):**
  - Increments when DMA is valid and CPU is granted.
  - Clears when DMA is granted or `dma_req_valid` is low.
  - Saturates at `STARVE_LIMIT`.
- **Memory outputs on a grant:** `mem_*` carry the granted payload combinationally.
- **Memory outputs with no grant:** `mem_write_en = 0`. `mem_addr` and `mem_in_data` carry the CPU payload, which is don't-care.
- **Responses:** every accepted access, read or write, produces exactly one `resp_valid` pulse on the owner's port, the cycle after acceptance.
  - `resp_rdata = mem_out_data` on that cycle.
  - The non-owner's `resp_valid` stays 0.
  - Both `resp_rdata` outputs are driven by `mem_out_data` at all times. Only `resp_valid` qualifies them.
- **No back-pressure:** responses are not back-pressured. Requesters must sink them.
- **Ordering:** back-to-back accesses to the same word from different requesters are ordered by grant order. A read granted the cycle after a write returns the written data.

## Timing
- **Reset values:** `cpu_resp_valid = dma_resp_valid = 0`, `starve_cnt = 0`, owner register = CPU. `*_req_ready` and `mem_*` are combinational from inputs.
- **Throughput:** one access per cycle. Grant-to-response latency is exactly 1 cycle.
- **Both requesters valid continuously with `STARVE_LIMIT = 4`:** grants repeat C,C,C,C,D, i.e. a 5-cycle period.
- **DMA drops `valid` mid-wait:** `starve_cnt` clears the next edge.
- **Reset asserted with a response pending:** the response is dropped, with no `resp_valid` after reset release. A RAM write already clocked stays committed.
- **First cycle after reset release:** requests are accepted normally.
- **`STARVE_LIMIT = 1`:** strict alternation under full contention.

## Structure
- **Package `dcache_arb_pkg`:**
  - Requester index constants `REQ_CPU = 0` and `REQ_DMA = 1`.
  - Request struct typedef `{we[3:0], addr, wdata}`.
- **Modules:** single module. The grant logic, starvation counter and response-owner register are small enough that no sub-module is warranted.

## Test plan
- **CPU-only traffic:** CPU writes `we=4'hF` to addr 0x10 data 0xDEADBEEF, then reads addr 0x10 -> read `cpu_resp_valid` one cycle later with rdata 0xDEADBEEF; `dma_resp_valid` stays 0.
- **Byte write:** DMA writes `we=4'b0010` data 0x0000AB00 to a word holding 0x11223344, then reads it -> rdata 0x1122AB44.
- **Full contention, `STARVE_LIMIT = 4`, 20 cycles:** exactly 16 CPU and 4 DMA grants in pattern CCCCD. Each response appears on the correct port one cycle after its grant.
- **Cross-requester hazard:** DMA write 0x5 to addr 0x20 granted in cycle n, CPU read addr 0x20 granted in cycle n+1 -> CPU rdata 0x5.
- **Reset mid-operation:** assert `rst` asynchronously between a read grant and its response -> no `resp_valid`; `starve_cnt` at 0 after release.
- **Idle:** both `valid` low -> `mem_write_en = 0`, no `resp_valid` pulses, `starve_cnt` holds 0.
